key_bounce_gen: RTL

KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

---
 rtl/key_bounce_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/key_bounce_gen.sv
// Emulated mechanical push-button: on each start request it drives a bouncy press,
// a stable low hold and a bouncy release on key_out, pseudo-randomised by an LFSR.
module key_bounce_gen #(
    parameter int          BOUNCE_CNT = 3,
    parameter int          BOUNCE_MAX = 16,
    parameter int          HOLD_LEN   = 1000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] press_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] P_BOUNCE = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] R_BOUNCE = 2'd3;

    localparam int SEG_W  = $clog2(BOUNCE_MAX + 1);
    localparam int HOLD_W = $clog2(HOLD_LEN + 1);
    localparam int IDX_W  = (2 * BOUNCE_CNT + 1 > 2) ? $clog2(2 * BOUNCE_CNT + 1) : 1;

    localparam logic [7:0]        SEG_MASK  = 8'(BOUNCE_MAX - 1);
    localparam logic [SEG_W-1:0]  SEG_ONE   = SEG_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_LEN);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  LAST_SEG  = IDX_W'(2 * BOUNCE_CNT - 1);

    logic [1:0]        state;
    logic [15:0]       lfsr;
    logic [SEG_W-1:0]  seg_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  seg_idx;
    logic [SEG_W-1:0]  seg_len;

    // Segment length is taken from the LFSR value present at the edge that opens the segment.
    assign seg_len = SEG_W'(lfsr[7:0] & SEG_MASK) + SEG_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED;
            seg_cnt   <= '0;
            hold_cnt  <= '0;
            seg_idx   <= '0;
            key_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            press_cnt <= 3'd0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        key_out <= 1'b0;
                        if (BOUNCE_CNT > 0) begin
                            state   <= P_BOUNCE;
                            seg_cnt <= seg_len;
                            seg_idx <= '0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_INIT;
                        end
                    end
                end
                P_BOUNCE: begin
                    if (seg_cnt == SEG_ONE) begin
                        if (seg_idx == LAST_SEG) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_INIT;
                            key_out  <= 1'b0;
                        end else begin
                            seg_idx <= seg_idx + IDX_W'(1);
                            seg_cnt <= seg_len;
                            key_out <= ~key_out;
                        end
                    end else begin
                        seg_cnt <= seg_cnt - SEG_ONE;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_ONE) begin
                        if (BOUNCE_CNT > 0) begin
                            state   <= R_BOUNCE;
                            seg_idx <= '0;
                            seg_cnt <= seg_len;
                            key_out <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            key_out   <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            press_cnt <= press_cnt + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                R_BOUNCE: begin
                    if (seg_cnt == SEG_ONE) begin
                        if (seg_idx == LAST_SEG) begin
                            state     <= IDLE;
                            key_out   <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            press_cnt <= press_cnt + 3'd1;
                        end else begin
                            seg_idx <= seg_idx + IDX_W'(1);
                            seg_cnt <= seg_len;
                            key_out <= ~key_out;
                        end
                    end else begin
                        seg_cnt <= seg_cnt - SEG_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
